// File: rtl/token_controller_sparse.sv
// Token controller: walks every neuron of a core, integrating the active axons of
// the current tick through the neuron block, then writes back and offers spikes to the router.
module token_controller_sparse #(
  parameter int NUM_AXONS   = 256,
  parameter int NUM_NEURONS = 256,
  parameter int NUM_WEIGHTS = 4,
  parameter int SPARSE      = 1,
  localparam int AW = $clog2(NUM_AXONS),
  localparam int NW = $clog2(NUM_NEURONS),
  localparam int WI = $clog2(NUM_WEIGHTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [NUM_AXONS-1:0] axon_spikes,
  input  logic [NUM_AXONS-1:0] synapses,
  input  logic                 spike_in,
  input  logic                 spike_ready,
  input  logic                 cfg_we,
  input  logic [AW-1:0]        cfg_addr,
  input  logic [WI-1:0]        cfg_data,
  output logic                 scheduler_set,
  output logic                 scheduler_clr,
  output logic [NW-1:0]        csram_addr,
  output logic                 csram_write,
  output logic [WI-1:0]        neuron_instruction,
  output logic                 neuron_reg_en,
  output logic                 next_neuron,
  output logic                 write_current_potential,
  output logic                 spike_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    LOAD  = 3'd2,
    INTEG = 3'd3,
    WRITE = 3'd4,
    NEXT  = 3'd5,
    CLR   = 3'd6
  } state_t;

  localparam logic [NUM_AXONS-1:0] ONE_HOT0  = NUM_AXONS'(1);
  localparam logic [AW-1:0]        LAST_AXON = AW'(NUM_AXONS - 1);
  localparam logic [NW-1:0]        LAST_NRN  = NW'(NUM_NEURONS - 1);

  state_t               state;
  logic [NUM_AXONS-1:0] mask;
  logic [AW-1:0]        idx;
  logic [WI-1:0]        type_table [NUM_AXONS];

  logic [NUM_AXONS-1:0] src_mask;
  logic [NUM_AXONS-1:0] rest_mask;
  logic [AW-1:0]        pick;
  logic [AW-1:0]        next_idx;

  function automatic logic [AW-1:0] lowest_set(input logic [NUM_AXONS-1:0] m);
    logic [AW-1:0] r;
    r = '0;
    for (int k = NUM_AXONS - 1; k >= 0; k--) begin
      if (m[k]) r = AW'(k);
    end
    return r;
  endfunction

  // In LOAD the freshly captured row feeds the encoder so the first axon issues without a bubble.
  always_comb begin
    src_mask  = (state == LOAD) ? (axon_spikes & synapses) : mask;
    pick      = lowest_set(src_mask);
    rest_mask = src_mask & ~(ONE_HOT0 << pick);
    next_idx  = idx + AW'(1);
  end

  // Axon-type table: not reset, writable only while idle.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) type_table[cfg_addr] <= cfg_data;
  end

  // Sequencer; every output is registered and reflects the state it was loaded for.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      mask                    <= '0;
      idx                     <= '0;
      scheduler_set           <= 1'b0;
      scheduler_clr           <= 1'b0;
      csram_addr              <= '0;
      csram_write             <= 1'b0;
      neuron_instruction      <= '0;
      neuron_reg_en           <= 1'b0;
      next_neuron             <= 1'b0;
      write_current_potential <= 1'b0;
      spike_valid             <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      error                   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (tick) begin
            state         <= SET;
            scheduler_set <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SET: begin
          scheduler_set           <= 1'b0;
          csram_addr              <= '0;
          state                   <= LOAD;
          next_neuron             <= 1'b1;
          write_current_potential <= 1'b1;
          neuron_reg_en           <= 1'b1;
        end
        LOAD: begin
          next_neuron             <= 1'b0;
          write_current_potential <= 1'b0;
          idx                     <= '0;
          if (SPARSE != 0) begin
            mask <= rest_mask;
            if (src_mask == '0) begin
              state         <= WRITE;
              neuron_reg_en <= 1'b0;
            end else begin
              state              <= INTEG;
              neuron_reg_en      <= 1'b1;
              neuron_instruction <= type_table[pick];
            end
          end else begin
            mask          <= src_mask;
            state         <= INTEG;
            neuron_reg_en <= src_mask[0];
            if (src_mask[0]) neuron_instruction <= type_table[0];
          end
        end
        INTEG: begin
          if (SPARSE != 0) begin
            if (mask == '0) begin
              state         <= WRITE;
              neuron_reg_en <= 1'b0;
            end else begin
              neuron_reg_en      <= 1'b1;
              neuron_instruction <= type_table[pick];
              mask               <= rest_mask;
            end
          end else begin
            if (idx == LAST_AXON) begin
              state         <= WRITE;
              neuron_reg_en <= 1'b0;
            end else begin
              idx           <= next_idx;
              neuron_reg_en <= mask[next_idx];
              if (mask[next_idx]) neuron_instruction <= type_table[next_idx];
            end
          end
        end
        WRITE: begin
          if (!spike_valid) begin
            if (spike_in) begin
              spike_valid <= 1'b1;
            end else begin
              csram_write <= 1'b1;
              state       <= NEXT;
            end
          end else if (spike_ready) begin
            spike_valid <= 1'b0;
            csram_write <= 1'b1;
            state       <= NEXT;
          end
        end
        NEXT: begin
          csram_write <= 1'b0;
          if (csram_addr == LAST_NRN) begin
            state         <= CLR;
            scheduler_clr <= 1'b1;
            done          <= 1'b1;
          end else begin
            csram_addr              <= csram_addr + NW'(1);
            state                   <= LOAD;
            next_neuron             <= 1'b1;
            write_current_potential <= 1'b1;
            neuron_reg_en           <= 1'b1;
          end
        end
        CLR: begin
          scheduler_clr <= 1'b0;
          done          <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if ((tick || cfg_we) && state != IDLE) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_token_controller_sparse.sv
// Bench: drives a sparse and a dense controller with random ticks and compares
// instruction streams, write-backs, handshakes and timing against a rule-level model.
module tb_token_controller_sparse;
  localparam int NA = 8;
  localparam int NN = 4;
  localparam int NWT = 4;
  localparam int AW = 3;
  localparam int NW = 2;
  localparam int WI = 2;

  typedef struct packed {
    logic          tick;
    logic [NA-1:0] axon_spikes;
    logic [NA-1:0] synapses;
    logic          spike_in;
    logic          spike_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [WI-1:0] cfg_data;
  } in_t;

  typedef struct packed {
    logic          set_p;
    logic          clr_p;
    logic [NW-1:0] addr;
    logic          wr;
    logic [WI-1:0] instr;
    logic          reg_en;
    logic          nn;
    logic          wcp;
    logic          sv;
    logic          busy;
    logic          done;
    logic          err;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  in_t  din [2];

  logic ss0, sc0, wr0, re0, nn0, wc0, sv0, bz0, dn0, er0;
  logic ss1, sc1, wr1, re1, nn1, wc1, sv1, bz1, dn1, er1;
  logic [NW-1:0] ad0, ad1;
  logic [WI-1:0] in0, in1;

  always #5 clk = ~clk;

  token_controller_sparse #(.NUM_AXONS(NA), .NUM_NEURONS(NN), .NUM_WEIGHTS(NWT), .SPARSE(1)) u_sparse (
    .clk(clk), .rst(rst), .tick(din[0].tick), .axon_spikes(din[0].axon_spikes),
    .synapses(din[0].synapses), .spike_in(din[0].spike_in), .spike_ready(din[0].spike_ready),
    .cfg_we(din[0].cfg_we), .cfg_addr(din[0].cfg_addr), .cfg_data(din[0].cfg_data),
    .scheduler_set(ss0), .scheduler_clr(sc0), .csram_addr(ad0), .csram_write(wr0),
    .neuron_instruction(in0), .neuron_reg_en(re0), .next_neuron(nn0),
    .write_current_potential(wc0), .spike_valid(sv0), .busy(bz0), .done(dn0), .error(er0));

  token_controller_sparse #(.NUM_AXONS(NA), .NUM_NEURONS(NN), .NUM_WEIGHTS(NWT), .SPARSE(0)) u_dense (
    .clk(clk), .rst(rst), .tick(din[1].tick), .axon_spikes(din[1].axon_spikes),
    .synapses(din[1].synapses), .spike_in(din[1].spike_in), .spike_ready(din[1].spike_ready),
    .cfg_we(din[1].cfg_we), .cfg_addr(din[1].cfg_addr), .cfg_data(din[1].cfg_data),
    .scheduler_set(ss1), .scheduler_clr(sc1), .csram_addr(ad1), .csram_write(wr1),
    .neuron_instruction(in1), .neuron_reg_en(re1), .next_neuron(nn1),
    .write_current_potential(wc1), .spike_valid(sv1), .busy(bz1), .done(dn1), .error(er1));

  // Reference state: type table, per-neuron synapse rows, firing and router stall lengths.
  logic [WI-1:0] tbl   [NA];
  logic [NA-1:0] syn   [NN];
  logic          fire  [NN];
  int            stall [NN];
  logic          exp_err [2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic out_t get_out(input int d);
    out_t o;
    if (d == 0) o = '{ss0, sc0, ad0, wr0, in0, re0, nn0, wc0, sv0, bz0, dn0, er0};
    else        o = '{ss1, sc1, ad1, wr1, in1, re1, nn1, wc1, sv1, bz1, dn1, er1};
    return o;
  endfunction

  task automatic program_table(input int d);
    for (int i = 0; i < NA; i++) begin
      @(negedge clk);
      din[d].cfg_we   = 1'b1;
      din[d].cfg_addr = AW'(i);
      din[d].cfg_data = tbl[i];
    end
    @(negedge clk);
    din[d].cfg_we = 1'b0;
  endtask

  // One full timestep on DUT d; inj plants a tick during INTEG and a table write during LOAD.
  task automatic run_tick(input int d, input logic [NA-1:0] spikes, input bit inj);
    out_t o;
    logic [WI-1:0] exp_q[$];
    logic [WI-1:0] obs_q[$];
    int wr_q[$];
    int exp_cyc, exp_sv, cyc, sv_cyc, set_cnt, clr_cnt, done_cnt, stall_left, bad_sv, bad_wcp;
    bit got_done, inj_t, inj_c;
    logic [NA-1:0] m;
    exp_cyc = 3;
    exp_sv = 0;
    for (int n = 0; n < NN; n++) begin
      m = spikes & syn[n];
      exp_cyc += 3 + ((d == 0) ? $countones(m) : NA) + (fire[n] ? 1 + stall[n] : 0);
      if (fire[n]) exp_sv += stall[n] + 1;
      for (int i = 0; i < NA; i++) if (m[i]) exp_q.push_back(tbl[i]);
    end
    if (inj) exp_err[d] = 1'b1;
    {sv_cyc, set_cnt, clr_cnt, done_cnt, bad_sv, bad_wcp} = '0;
    got_done = 1'b0; inj_t = 1'b0; inj_c = 1'b0;
    stall_left = 0;
    @(negedge clk);
    din[d].axon_spikes = spikes;
    din[d].tick = 1'b1;
    cyc = 1;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      @(negedge clk);
      din[d].tick = 1'b0;
      din[d].cfg_we = 1'b0;
      o = get_out(d);
      cyc++;
      if (o.reg_en && !o.nn) obs_q.push_back(o.instr);
      if (o.wr) wr_q.push_back(int'(o.addr));
      if (o.sv && !fire[o.addr]) bad_sv++;
      if (o.wcp != o.nn) bad_wcp++;
      sv_cyc += int'(o.sv); set_cnt += int'(o.set_p); clr_cnt += int'(o.clr_p); done_cnt += int'(o.done);
      if (o.done) got_done = 1'b1;
      din[d].synapses = syn[o.addr];
      din[d].spike_in = fire[o.addr];
      if (o.sv) begin
        if (stall_left > 0) begin
          din[d].spike_ready = 1'b0;
          stall_left--;
        end else begin
          din[d].spike_ready = 1'b1;
        end
      end else begin
        din[d].spike_ready = 1'b0;
        stall_left = stall[o.addr];
      end
      if (inj && !inj_t && o.reg_en && !o.nn) begin
        din[d].tick = 1'b1;
        inj_t = 1'b1;
      end
      if (inj && !inj_c && o.nn) begin
        din[d].cfg_we   = 1'b1;
        din[d].cfg_addr = '0;
        din[d].cfg_data = ~tbl[0];
        inj_c = 1'b1;
      end
    end
    check("done_seen", 32'(got_done), 32'd1);
    check("tick_cycles", 32'(cyc), 32'(exp_cyc));
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("sched_set", 32'(set_cnt), 32'd1);
    check("sched_clr", 32'(clr_cnt), 32'd1);
    check("valid_cycles", 32'(sv_cyc), 32'(exp_sv));
    check("valid_wrong_neuron", 32'(bad_sv), 32'd0);
    check("wcp_vs_next_neuron", 32'(bad_wcp), 32'd0);
    check("write_count", 32'(wr_q.size()), 32'(NN));
    for (int i = 0; i < wr_q.size() && i < NN; i++) check("write_addr", 32'(wr_q[i]), 32'(i));
    check("instr_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) check("instr", 32'(obs_q[i]), 32'(exp_q[i]));
    check("error_flag", 32'(o.err), 32'(exp_err[d]));
    din[d].tick = 1'b0;
    din[d].cfg_we = 1'b0;
    @(negedge clk);
    o = get_out(d);
    check("idle_busy", 32'(o.busy), 32'd0);
    check("idle_done", 32'(o.done), 32'd0);
  endtask

  task automatic set_rows(input logic all_ones);
    for (int n = 0; n < NN; n++) begin
      syn[n]   = all_ones ? '1 : NA'($urandom);
      fire[n]  = 1'b0;
      stall[n] = 0;
    end
  endtask

  // Reset while the router holds off a spike; everything must clear at once.
  task automatic reset_in_stall(input int d);
    out_t o;
    bit got_sv;
    for (int n = 0; n < NN; n++) begin
      fire[n] = 1'b1;
      syn[n] = '1;
    end
    got_sv = 1'b0;
    @(negedge clk);
    din[d].axon_spikes = 8'h03;
    din[d].tick = 1'b1;
    for (int k = 0; k < 200 && !got_sv; k++) begin
      @(negedge clk);
      din[d].tick = 1'b0;
      o = get_out(d);
      din[d].synapses = syn[o.addr];
      din[d].spike_in = fire[o.addr];
      din[d].spike_ready = 1'b0;
      if (o.sv) got_sv = 1'b1;
    end
    check("stall_reached", 32'(got_sv), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    o = get_out(d);
    check("reset_outputs", 32'(o), 32'd0);
    exp_err[0] = 1'b0;
    exp_err[1] = 1'b0;
  endtask

  initial begin
    out_t o;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      din[d] = '0;
      exp_err[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_sparse", 32'(get_out(0)), 32'd0);
    check("reset_dense", 32'(get_out(1)), 32'd0);

    for (int i = 0; i < NA; i++) tbl[i] = WI'($urandom);
    program_table(0);
    program_table(1);

    // Two active axons at the ends of the row, all synapses present.
    set_rows(1'b1);
    run_tick(0, 8'h81, 1'b0);
    run_tick(1, 8'h81, 1'b0);

    // Nothing scheduled: sparse skips straight to write-back.
    run_tick(0, 8'h00, 1'b0);

    // Neuron 2 fires and the router holds it off for five cycles.
    set_rows(1'b0);
    fire[2] = 1'b1;
    stall[2] = 5;
    run_tick(0, 8'h5A, 1'b0);
    run_tick(1, 8'h5A, 1'b0);

    // Protocol errors are ignored but sticky; the table must keep entry 0.
    set_rows(1'b1);
    run_tick(0, 8'hA5, 1'b1);
    run_tick(1, 8'hA5, 1'b1);
    run_tick(0, 8'hFF, 1'b0);
    run_tick(1, 8'hFF, 1'b0);

    reset_in_stall(0);
    set_rows(1'b1);
    run_tick(0, 8'h81, 1'b0);
    reset_in_stall(1);
    set_rows(1'b1);
    run_tick(1, 8'h81, 1'b0);

    for (int it = 0; it < 8; it++) begin
      for (int n = 0; n < NN; n++) begin
        syn[n]   = NA'($urandom);
        fire[n]  = 1'($urandom_range(0, 1));
        stall[n] = int'($urandom_range(0, 3));
      end
      run_tick(it % 2, (it == 4) ? 8'h00 : NA'($urandom), 1'b0);
    end

    o = get_out(0);
    check("final_error_sparse", 32'(o.err), 32'(exp_err[0]));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
